// File: rtl/sd_deserializer.sv
// sd_deserializer: slave-receive serial-data deserializer.
// Builds MSB-first L/R words and hands them out through a one-entry valid/ready register.

package sd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        L,
        R
    } ws_state_t;

    typedef enum logic [1:0] {
        MT,
        ST,
        MR,
        SR
    } mode_t;

    typedef enum logic {
        f16bits,
        f32bits
    } frame_size_t;

    typedef struct packed {
        mode_t       mode;
        logic        stop;
        frame_size_t frame_size;
    } OP_t;

endpackage

module sd_deserializer
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_,
    input  OP_t         OP,
    input  ws_state_t   state,
    input  logic        sd,
    input  logic        rx_ready,
    input  logic        cnt_clr,
    output logic [31:0] rx_data,
    output logic        rx_chan,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        overrun,
    output logic [7:0]  err_cnt,
    output logic [7:0]  ovr_cnt
);

    typedef enum logic {
        WAIT,
        SHIFT
    } fsm_t;

    fsm_t        fsm_q;
    fsm_t        fsm_d;
    ws_state_t   prev_state;
    logic [30:0] sh_q;
    logic [30:0] sh_d;
    logic [31:0] sh_next;
    logic [4:0]  left_q;
    logic [4:0]  left_d;
    logic        chan_q;
    logic        chan_d;
    logic        f32_q;
    logic        f32_d;
    logic        en;
    logic        changed;
    logic        boundary;
    logic        start;
    logic        trunc;
    logic        done;
    logic        xfer;
    logic        load;
    logic        drop;

    assign en       = ((OP.mode == SR) || (OP.mode == MR)) && !OP.stop;
    assign changed  = (state != prev_state);
    assign boundary = changed && ((state == L) || (state == R));
    // The completed word is the bits gathered so far plus the one on the line now.
    assign sh_next  = {sh_q, sd};

    assign xfer = rx_valid && rx_ready;
    assign load = done && (!rx_valid || rx_ready);
    assign drop = done && rx_valid && !rx_ready;

    // Channel state history for boundary detection.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            prev_state <= IDLE;
        end else begin
            prev_state <= state;
        end
    end

    // FSM and shift datapath registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            fsm_q  <= WAIT;
            sh_q   <= '0;
            left_q <= '0;
            chan_q <= 1'b0;
            f32_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            sh_q   <= sh_d;
            left_q <= left_d;
            chan_q <= chan_d;
            f32_q  <= f32_d;
        end
    end

    // Next-state: start on a boundary, shift until bit 0, abort on early state change.
    always_comb begin
        fsm_d  = fsm_q;
        sh_d   = sh_q;
        left_d = left_q;
        chan_d = chan_q;
        f32_d  = f32_q;
        start  = 1'b0;
        trunc  = 1'b0;
        done   = 1'b0;
        if (!en) begin
            fsm_d = WAIT;
        end else begin
            unique case (fsm_q)
                WAIT: begin
                    start = boundary;
                end
                SHIFT: begin
                    if (changed) begin
                        trunc = 1'b1;
                        start = boundary;
                        if (!boundary) begin
                            fsm_d = WAIT;
                        end
                    end else begin
                        sh_d   = sh_next[30:0];
                        left_d = left_q - 5'd1;
                        if (left_q == 5'd1) begin
                            done  = 1'b1;
                            fsm_d = WAIT;
                        end
                    end
                end
            endcase
            if (start) begin
                fsm_d  = SHIFT;
                sh_d   = {30'b0, sd};
                chan_d = (state == R);
                f32_d  = (OP.frame_size == f32bits);
                left_d = (OP.frame_size == f32bits) ? 5'd31 : 5'd15;
            end
        end
    end

    // Single-entry output register with valid/ready handshake.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rx_data  <= '0;
            rx_chan  <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            if (load) begin
                rx_data  <= sh_next;
                rx_chan  <= chan_q;
                rx_valid <= 1'b1;
            end else if (xfer) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Registered one-cycle error pulses.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= trunc;
            overrun   <= drop;
        end
    end

    // Saturating error counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            err_cnt <= '0;
            ovr_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= '0;
            ovr_cnt <= '0;
        end else begin
            if (trunc && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (drop && (ovr_cnt != 8'hFF)) begin
                ovr_cnt <= ovr_cnt + 8'd1;
            end
        end
    end

endmodule
